// File: rtl/apb_cmd_master.sv
// APB4 requester: turns a vld/rdy command channel into single APB transfers and returns a vld/rdy response.
// Optional ACCESS-phase timeout is compiled in when APB_CMD_TIMEOUT_EN is defined.
module apb_cmd_master #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_slverr,
  output logic [ADDR_W-1:0]     p_addr,
  output logic [2:0]            p_prot,
  output logic                  p_sel,
  output logic                  p_enable,
  output logic                  p_write,
  output logic [DATA_W-1:0]     p_wdata,
  output logic [DATA_W/8-1:0]   p_strb,
  input  logic                  p_ready,
  input  logic [DATA_W-1:0]     p_rdata,
  input  logic                  p_slverr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state;
  logic   accept;
  logic   to_hit;

  assign cmd_rdy = (state == S_IDLE) || ((state == S_RESP) && rsp_rdy);
  assign accept  = cmd_vld && cmd_rdy;

`ifdef APB_CMD_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

  logic [TO_CNT_W-1:0] to_cnt;

  // SETUP always precedes ACCESS, so clearing there zeroes the count on ACCESS entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == S_SETUP) begin
      to_cnt <= '0;
    end else if ((state == S_ACCESS) && !p_ready) begin
      to_cnt <= to_cnt + TO_CNT_W'(1);
    end
  end

  assign to_hit = (state == S_ACCESS) && !p_ready && (to_cnt == TO_LAST);
`else
  logic [TO_CNT_W-1:0] unused_to_cfg;

  assign unused_to_cfg = TO_CNT_W'(TIMEOUT_CYC);
  assign to_hit        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rsp_vld    <= 1'b0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
      p_addr     <= '0;
      p_prot     <= '0;
      p_sel      <= 1'b0;
      p_enable   <= 1'b0;
      p_write    <= 1'b0;
      p_wdata    <= '0;
      p_strb     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
        end
        S_SETUP: begin
          p_enable <= 1'b1;
          state    <= S_ACCESS;
        end
        S_ACCESS: begin
          if (p_ready) begin
            p_sel      <= 1'b0;
            p_enable   <= 1'b0;
            p_strb     <= '0;
            rsp_vld    <= 1'b1;
            rsp_rdata  <= p_write ? '0 : p_rdata;
            rsp_slverr <= p_slverr;
            state      <= S_RESP;
          end else if (to_hit) begin
            p_sel      <= 1'b0;
            p_enable   <= 1'b0;
            p_strb     <= '0;
            rsp_vld    <= 1'b1;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_rdy) begin
            rsp_vld    <= 1'b0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Accept is shared by IDLE and RESP; placed last so it overrides the RESP->IDLE move
      if (accept) begin
        p_addr   <= cmd_addr;
        p_write  <= cmd_write;
        p_wdata  <= cmd_wdata;
        p_strb   <= cmd_write ? cmd_strb : '0;
        p_prot   <= cmd_prot;
        p_sel    <= 1'b1;
        p_enable <= 1'b0;
        state    <= S_SETUP;
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: directed commands push expected responses, a monitor pops and compares.
// Build with APB_CMD_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT_CYC=8).
module tb_apb_cmd_master;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_vld, cmd_rdy, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_vld, rsp_rdy, rsp_slverr;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] p_addr;
  logic [2:0]    p_prot;
  logic          p_sel, p_enable, p_write, p_ready, p_slverr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic [SW-1:0] p_strb;

  always #5 clk = ~clk;

  apb_cmd_master #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8), .TO_CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .p_addr(p_addr), .p_prot(p_prot), .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write),
    .p_wdata(p_wdata), .p_strb(p_strb), .p_ready(p_ready), .p_rdata(p_rdata), .p_slverr(p_slverr)
  );

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired, got no event expected one", name);
  endtask

  // Slave model: ready after sl_wait extra ACCESS cycles, never when sl_hang
  int            sl_wait  = 0;
  logic [DW-1:0] sl_rdata = '0;
  logic          sl_err   = 1'b0;
  logic          sl_hang  = 1'b0;
  int            acc_cnt  = 0;

  initial begin
    p_ready  = 1'b0;
    p_rdata  = 32'hDEAD_BEEF;
    p_slverr = 1'b0;
    forever begin
      @(negedge clk);
      if (p_sel && p_enable) begin
        if (!sl_hang && acc_cnt >= sl_wait) begin
          p_ready  = 1'b1;
          p_rdata  = sl_rdata;
          p_slverr = sl_err;
        end else begin
          p_ready  = 1'b0;
          p_rdata  = 32'hDEAD_BEEF;
          p_slverr = 1'b0;
        end
        acc_cnt++;
      end else begin
        p_ready  = 1'b0;
        p_rdata  = 32'hDEAD_BEEF;
        p_slverr = 1'b0;
        acc_cnt  = 0;
      end
    end
  end

  // Monitor: every retired response is checked against the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && rsp_vld && rsp_rdy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got response 0x%0h expected none", rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        chk("sb_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("sb_slverr", 64'(rsp_slverr), 64'(e.err));
      end
    end
  end

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic [DW-1:0] er, input logic ee,
                       output int acc_cyc, output int waited);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = 3'b010;
    cmd_vld   = 1'b1;
    waited    = 0;
    acc_cyc   = -1;
    while (acc_cyc < 0 && waited < 50) begin
      @(negedge clk);
      if (cmd_rdy) begin
        acc_cyc = cyc;
        exp_q.push_back('{er, ee});
      end else begin
        waited++;
      end
    end
    if (acc_cyc < 0) fail_bound("cmd_accept");
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_vld(input int lim);
    int n = 0;
    while (!rsp_vld && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_vld) fail_bound("wait_rsp_vld");
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_vld) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || rsp_vld) fail_bound("drain");
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc, wt, en_cnt, n;
    logic ok;
    rst_n = 1'b0; cmd_vld = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({p_sel, p_enable, p_write, p_strb, p_prot, rsp_vld, rsp_slverr, p_addr}), 64'(0));
    chk("rst_data", {p_wdata, rsp_rdata}, 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: zero-wait write
    issue(1'b1, 16'h0010, 32'hA5A5_5A5A, 4'hF, 32'h0, 1'b0, acc, wt);
    @(negedge clk);
    chk("t1_setup", 64'({p_sel, p_enable, p_write, p_strb, p_prot, p_addr}),
        64'({1'b1, 1'b0, 1'b1, 4'hF, 3'b010, 16'h0010}));
    chk("t1_wdata", 64'(p_wdata), 64'(32'hA5A5_5A5A));
    @(negedge clk);
    chk("t1_access", 64'({p_sel, p_enable, p_strb}), 64'({1'b1, 1'b1, 4'hF}));
    @(negedge clk);
    chk("t1_rsp_vld", 64'(rsp_vld), 64'(1));
    chk("t1_latency", 64'(cyc - acc), 64'(3));
    chk("t1_after", 64'({p_sel, p_enable, p_strb, p_addr}), 64'({1'b0, 1'b0, 4'h0, 16'h0010}));
    drain();

    // 2: read with 3 wait states, response held off for 5 cycles
    rsp_rdy = 1'b0; sl_wait = 3; sl_rdata = 32'h1234_5678;
    issue(1'b0, 16'h0014, 32'hFFFF_FFFF, 4'hF, 32'h1234_5678, 1'b0, acc, wt);
    @(negedge clk);
    chk("t2_setup", 64'({p_sel, p_enable, p_write, p_strb}), 64'({1'b1, 1'b0, 1'b0, 4'h0}));
    en_cnt = 0; n = 0;
    while (!rsp_vld && n < 20) begin
      if (p_enable) en_cnt++;
      @(negedge clk);
      n++;
    end
    if (!rsp_vld) fail_bound("t2_rsp_vld");
    chk("t2_enable_cycles", 64'(en_cnt), 64'(4));
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(rsp_vld === 1'b1 && rsp_rdata === 32'h1234_5678)) ok = 1'b0;
      @(negedge clk);
    end
    chk("t2_hold", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
    rsp_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t2_cleared", 64'({rsp_vld, rsp_rdata}), 64'(0));
    drain();

    // 3: back-to-back, second command accepted while the first response retires
    rsp_rdy = 1'b0; sl_wait = 0; sl_rdata = 32'h1111_2222;
    issue(1'b0, 16'h0020, 32'h0, 4'h0, 32'h1111_2222, 1'b0, acc, wt);
    wait_vld(10);
    @(posedge clk);
    #1;
    rsp_rdy = 1'b1;
    issue(1'b1, 16'h0024, 32'hCAFE_F00D, 4'h3, 32'h0, 1'b0, acc, wt);
    chk("t3_same_cycle", 64'(wt), 64'(0));
    @(negedge clk);
    chk("t3_no_idle", 64'({p_sel, p_enable, rsp_vld, p_strb, p_addr}),
        64'({1'b1, 1'b0, 1'b0, 4'h3, 16'h0024}));
    drain();

    // 4: slave error then a clean write
    sl_err = 1'b1;
    issue(1'b1, 16'h0040, 32'h0000_0001, 4'hF, 32'h0, 1'b1, acc, wt);
    drain();
    sl_err = 1'b0;
    issue(1'b1, 16'h0044, 32'h0000_0002, 4'hF, 32'h0, 1'b0, acc, wt);
    drain();

    // 5: slave never ready
    sl_hang = 1'b1;
`ifdef APB_CMD_TIMEOUT_EN
    sl_rdata = 32'h5555_AAAA;
    issue(1'b0, 16'h0050, 32'h0, 4'h0, 32'h0, 1'b1, acc, wt);
    en_cnt = 0; n = 0;
    do begin
      @(negedge clk);
      if (p_sel && p_enable) en_cnt++;
      n++;
    end while (!(!p_sel && rsp_vld) && n < 40);
    if (n >= 40) fail_bound("t5_timeout");
    chk("t5_to_cycles", 64'(en_cnt), 64'(8));
    drain();
    issue(1'b0, 16'h0060, 32'h0, 4'h0, 32'h0, 1'b0, acc, wt);
    repeat (3) @(negedge clk);
`else
    issue(1'b1, 16'h0050, 32'h0, 4'hF, 32'h0, 1'b1, acc, wt);
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (p_sel !== 1'b1 || rsp_vld !== 1'b0) ok = 1'b0;
    end
    chk("t5_no_timeout", 64'(ok), 64'(1));
`endif

    // 6: asynchronous reset in ACCESS
    chk("t6_in_access", 64'({p_sel, p_enable}), 64'({1'b1, 1'b1}));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async", 64'({p_sel, p_enable, rsp_vld}), 64'(0));
    exp_q.delete();
    sl_hang = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_cmd_rdy", 64'(cmd_rdy), 64'(1));
    sl_wait = 1; sl_rdata = 32'h600D_D00D;
    issue(1'b0, 16'h0070, 32'h0, 4'h0, 32'h600D_D00D, 1'b0, acc, wt);
    drain();

    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
